timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
Control/status block for the 8-bit timer counter.
- Holds the TCR (control) and TSR (status) registers.
- Generates the divided count clock `clk_in` from `pclk`, plus the `en`/`load`/`updown` controls and the one-cycle `tcr_reconf` pulse that drive the counter.
- Monitors `cnt` for overflow/underflow, sets sticky status flags and raises the interrupt.
- Sits between the bus register decode and the counter.

Parameters:
- DIV_W, 4, prescaler width; fixes the maximum division at pclk/2^DIV_W.

Ports:
- pclk  input  1  system clock
- preset_n  input  1  asynchronous active-low reset
- tcr_wr  input  1  one-cycle TCR write strobe
- tcr_wdata  input  8  TCR write data
- tsr_wr  input  1  one-cycle TSR write strobe (write-1-to-clear)
- tsr_wdata  input  2  TSR write data
- cnt  input  8  current counter value
- tcr  output  8  TCR readback; reserved bits read 0
- tsr  output  2  status: [0] ovf, [1] udf
- en  output  1  counter enable = tcr[5]
- load  output  1  counter load select = tcr[7]
- updown  output  1  count direction = tcr[4]; 1 = down
- clk_in  output  1  divided count clock to the counter
- tcr_reconf  output  1  one-cycle reconfigure pulse
- irq  output  1  interrupt

Behaviour:
- Clock and reset:
  - Single clock `pclk`; reset is asynchronous and active-low on `preset_n`.
  - Every flop clears on reset: tcr=8'h00, tsr=2'b00, div_cnt=0, tcr_reconf=0, cnt_q=8'h00, reconf_d=0.
  - So all outputs reset to 0.
- TCR bit map:
  - [1:0] cks: clock select.
  - [3:2] reserved: write ignored, read 0.
  - [4] updown.
  - [5] en.
  - [6] ie: interrupt enable.
  - [7] load.
- TCR write:
  - tcr_wr=1 updates tcr at the next pclk edge.
  - en/load/updown change in that same cycle as tcr.
- Prescaler:
  - div_cnt is DIV_W bits and increments every pclk while en=1.
  - It is held at 0 while en=0, and wraps naturally.
- Clock select: clk_in = div_cnt[cks], giving 00 = pclk/2, 01 = /4, 10 = /8, 11 = /16.
  - clk_in is a registered-source square wave.
  - The counter sees exactly one rising edge per period.
  - clk_in=0 while en=0.
- Reconfigure pulse:
  - tcr_reconf is a registered copy of tcr_wr.
  - It is high for exactly the one cycle after each TCR write, coincident with the new tcr value.
  - Back-to-back writes give back-to-back pulses.
- Wrap detection:
  - cnt_q samples cnt every cycle; reconf_d samples tcr_reconf every cycle.
  - Overflow condition: en & ~updown & cnt_q==8'hFF & cnt==8'h00 & ~reconf_d.
  - Underflow condition: en & updown & cnt_q==8'h00 & cnt==8'hFF & ~reconf_d.
  - A value change caused by reconfiguration (reconf_d=1) never sets a flag.
- Status register:
  - A detected wrap sets tsr[0] (ovf) or tsr[1] (udf) at the next edge.
  - tsr_wr with tsr_wdata[i]=1 clears bit i; a written 0 leaves the bit unchanged.
  - If a set and a clear of the same bit coincide, set wins.
- Interrupt: irq = tcr[6] & (tsr[0] | tsr[1]), combinational from flops.
- Reset mid-operation: everything returns to reset values immediately; no pending pulse survives.

Optional Feature:
- Macro: TIMER_AUTORELOAD_EN.
- Defined:
  - When a wrap is detected while load=1, tcr_reconf additionally pulses for one cycle in the cycle the flag sets.
  - The counter therefore reloads tdr.
  - That reload is masked from wrap detection through reconf_d.
  - The flag still sets.
- Undefined: tcr_reconf only follows TCR writes; the counter free-wraps.

Decomposition:
- Package timer_pkg holds:
  - TCR bit-position constants (CKS_LSB/MSB, UPDOWN_BIT, EN_BIT, IE_BIT, LOAD_BIT).
  - TSR_OVF/TSR_UDF indices.
  - cks encodings CKS_DIV2/4/8/16.
  - TCR_RESERVED_MASK = 8'h0C.
- Sub-module timer_prescaler contains div_cnt and the clk_in mux.
  - Inputs: pclk, preset_n, en, cks.
  - Output: clk_in.

Test Plan:
1. Reset, then write TCR=8'h20 (en, up, /2) -> tcr_reconf high for exactly 1 cycle; clk_in toggles every pclk; tcr reads 8'h20.
2. Write TCR=8'h2F -> tcr reads 8'h23 (reserved bits dropped); clk_in period 16 pclk (cks=11).
3. Up mode with cnt driven FF->00 -> tsr=2'b01 next cycle; with ie=1, irq=1. Then tsr_wr with wdata=2'b01 -> tsr=00, irq=0.
4. Down mode with cnt driven 00->FF -> tsr[1]=1. With cnt_q=FF, write TCR, then drive cnt=00 in the reconf_d cycle -> no ovf flag.
5. Wrap detected in the same cycle as a tsr_wr clearing that bit -> bit stays 1. Assert preset_n=0 mid-count -> all outputs 0 immediately.
6. With TIMER_AUTORELOAD_EN defined, load=1, up mode, cnt FF->00 -> tsr[0]=1 and tcr_reconf pulses once in the same cycle. Without the macro -> no pulse.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit timer control block.
// Holds TCR/TSR bit positions, clock-select encodings and the reserved mask.
package timer_pkg;

    localparam int CKS_LSB    = 0;
    localparam int CKS_MSB    = 1;
    localparam int UPDOWN_BIT = 4;
    localparam int EN_BIT     = 5;
    localparam int IE_BIT     = 6;
    localparam int LOAD_BIT   = 7;

    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;

    localparam logic [7:0] TCR_RESERVED_MASK = 8'h0C;

    typedef enum logic [1:0] {
        CKS_DIV2  = 2'b00,
        CKS_DIV4  = 2'b01,
        CKS_DIV8  = 2'b10,
        CKS_DIV16 = 2'b11
    } cks_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: free-running divider while enabled, clk_in picked by cks.
// Ports: pclk, preset_n, en, cks in; clk_in out (0 while en=0).
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic en,
    input  cks_e cks,
    output logic clk_in
);

    logic [DIV_W-1:0] div_cnt;
    logic             sel;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= div_cnt + DIV_W'(1);
        end else begin
            div_cnt <= '0;
        end
    end

    always_comb begin
        sel = 1'b0;
        unique case (cks)
            CKS_DIV2:  sel = div_cnt[0];
            CKS_DIV4:  sel = div_cnt[1];
            CKS_DIV8:  sel = div_cnt[2];
            CKS_DIV16: sel = div_cnt[3];
        endcase
    end

    // div_cnt lags en by one edge; gate so clk_in is 0 as soon as en drops
    assign clk_in = en & sel;

endmodule

// File: rtl/timer_ctrl.sv
// Timer control/status: TCR/TSR registers, count clock, wrap flags, irq.
// Optional TIMER_AUTORELOAD_EN: a wrap with load=1 also pulses tcr_reconf.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic       pclk,
    input  logic       preset_n,
    input  logic       tcr_wr,
    input  logic [7:0] tcr_wdata,
    input  logic       tsr_wr,
    input  logic [1:0] tsr_wdata,
    input  logic [7:0] cnt,
    output logic [7:0] tcr,
    output logic [1:0] tsr,
    output logic       en,
    output logic       load,
    output logic       updown,
    output logic       clk_in,
    output logic       tcr_reconf,
    output logic       irq
);

    logic [7:0] cnt_q;
    logic       reconf_d;
    logic       ovf_det;
    logic       udf_det;
    logic       reconf_nxt;
    logic [1:0] tsr_set;
    logic [1:0] tsr_clr;

    assign en     = tcr[EN_BIT];
    assign load   = tcr[LOAD_BIT];
    assign updown = tcr[UPDOWN_BIT];
    assign irq    = tcr[IE_BIT] & (tsr[TSR_OVF] | tsr[TSR_UDF]);

    // reconf_d masks the counter jump caused by a reconfigure/reload
    always_comb begin
        ovf_det = en & ~updown & (cnt_q == 8'hFF)
                & (cnt == 8'h00) & ~reconf_d;
        udf_det = en & updown & (cnt_q == 8'h00)
                & (cnt == 8'hFF) & ~reconf_d;
        tsr_set = 2'b00;
        tsr_set[TSR_OVF] = ovf_det;
        tsr_set[TSR_UDF] = udf_det;
        tsr_clr = tsr_wr ? tsr_wdata : 2'b00;
`ifdef TIMER_AUTORELOAD_EN
        reconf_nxt = tcr_wr | (load & (ovf_det | udf_det));
`else
        reconf_nxt = tcr_wr;
`endif
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            tcr        <= 8'h00;
            tsr        <= 2'b00;
            tcr_reconf <= 1'b0;
            cnt_q      <= 8'h00;
            reconf_d   <= 1'b0;
        end else begin
            if (tcr_wr) begin
                tcr <= tcr_wdata & ~TCR_RESERVED_MASK;
            end
            // set after clear: a coincident wrap keeps the flag
            tsr        <= (tsr & ~tsr_clr) | tsr_set;
            tcr_reconf <= reconf_nxt;
            cnt_q      <= cnt;
            reconf_d   <= tcr_reconf;
        end
    end

    timer_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .pclk    (pclk),
        .preset_n(preset_n),
        .en      (en),
        .cks     (cks_e'(tcr[CKS_MSB:CKS_LSB])),
        .clk_in  (clk_in)
    );

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: vector table plus clock/reset sequences.
// Expected values are hand-derived cycle by cycle.
module tb_timer_ctrl;

    logic       pclk;
    logic       preset_n;
    logic       tcr_wr;
    logic [7:0] tcr_wdata;
    logic       tsr_wr;
    logic [1:0] tsr_wdata;
    logic [7:0] cnt;
    logic [7:0] tcr;
    logic [1:0] tsr;
    logic       en;
    logic       load;
    logic       updown;
    logic       clk_in;
    logic       tcr_reconf;
    logic       irq;

    int checks = 0;
    int errors = 0;

`ifdef TIMER_AUTORELOAD_EN
    localparam logic AR = 1'b1;
`else
    localparam logic AR = 1'b0;
`endif

    typedef struct {
        logic       twr;
        logic [7:0] twd;
        logic       swr;
        logic [1:0] swd;
        logic [7:0] c;
        logic [7:0] e_tcr;
        logic [1:0] e_tsr;
        logic       e_rc;
        logic       e_irq;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    timer_ctrl #(.DIV_W(4)) dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .tcr_wr    (tcr_wr),
        .tcr_wdata (tcr_wdata),
        .tsr_wr    (tsr_wr),
        .tsr_wdata (tsr_wdata),
        .cnt       (cnt),
        .tcr       (tcr),
        .tsr       (tsr),
        .en        (en),
        .load      (load),
        .updown    (updown),
        .clk_in    (clk_in),
        .tcr_reconf(tcr_reconf),
        .irq       (irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic twr, input logic [7:0] twd,
                                input logic swr, input logic [1:0] swd,
                                input logic [7:0] c, input logic [7:0] et,
                                input logic [1:0] es, input logic rc,
                                input logic ei);
        vec_t v;
        v.twr = twr; v.twd = twd; v.swr = swr; v.swd = swd; v.c = c;
        v.e_tcr = et; v.e_tsr = es; v.e_rc = rc; v.e_irq = ei;
        return v;
    endfunction

    task automatic all_zero(input string nm);
        chk({nm, "_tcr"}, tcr, 8'h00);
        chk({nm, "_tsr"}, {6'd0, tsr}, 8'h00);
        chk({nm, "_en"}, {7'd0, en}, 8'h00);
        chk({nm, "_load"}, {7'd0, load}, 8'h00);
        chk({nm, "_updown"}, {7'd0, updown}, 8'h00);
        chk({nm, "_clk_in"}, {7'd0, clk_in}, 8'h00);
        chk({nm, "_reconf"}, {7'd0, tcr_reconf}, 8'h00);
        chk({nm, "_irq"}, {7'd0, irq}, 8'h00);
    endtask

    task automatic step(input logic twr, input logic [7:0] twd,
                        input logic swr, input logic [1:0] swd,
                        input logic [7:0] c);
        tcr_wr = twr; tcr_wdata = twd;
        tsr_wr = swr; tsr_wdata = swd; cnt = c;
        @(posedge pclk);
        #1;
    endtask

    initial begin
        int rises;
        int highs;
        logic prev;

        //         twr twd    swr swd    cnt    tcr    tsr    rc  irq
        vecs[0]  = mk(1, 8'h20, 0, 2'b00, 8'h00, 8'h20, 2'b00, 1, 0);
        vecs[1]  = mk(0, 8'h00, 0, 2'b00, 8'hFF, 8'h20, 2'b00, 0, 0);
        vecs[2]  = mk(0, 8'h00, 0, 2'b00, 8'h00, 8'h20, 2'b00, 0, 0);
        vecs[3]  = mk(0, 8'h00, 0, 2'b00, 8'hFF, 8'h20, 2'b00, 0, 0);
        vecs[4]  = mk(0, 8'h00, 0, 2'b00, 8'h00, 8'h20, 2'b01, 0, 0);
        vecs[5]  = mk(1, 8'h60, 0, 2'b00, 8'h00, 8'h60, 2'b01, 1, 1);
        vecs[6]  = mk(0, 8'h00, 1, 2'b01, 8'h00, 8'h60, 2'b00, 0, 0);
        vecs[7]  = mk(0, 8'h00, 1, 2'b10, 8'h00, 8'h60, 2'b00, 0, 0);
        vecs[8]  = mk(1, 8'h70, 0, 2'b00, 8'h00, 8'h70, 2'b00, 1, 0);
        vecs[9]  = mk(0, 8'h00, 0, 2'b00, 8'hFF, 8'h70, 2'b10, 0, 1);
        vecs[10] = mk(0, 8'h00, 1, 2'b10, 8'hFF, 8'h70, 2'b00, 0, 0);
        vecs[11] = mk(0, 8'h00, 0, 2'b00, 8'h00, 8'h70, 2'b00, 0, 0);
        vecs[12] = mk(0, 8'h00, 0, 2'b00, 8'hFF, 8'h70, 2'b10, 0, 1);
        vecs[13] = mk(0, 8'h00, 1, 2'b11, 8'hFF, 8'h70, 2'b00, 0, 0);
        vecs[14] = mk(1, 8'h60, 0, 2'b00, 8'hFF, 8'h60, 2'b00, 1, 0);
        vecs[15] = mk(0, 8'h00, 0, 2'b00, 8'hFF, 8'h60, 2'b00, 0, 0);
        vecs[16] = mk(0, 8'h00, 0, 2'b00, 8'h00, 8'h60, 2'b00, 0, 0);
        vecs[17] = mk(0, 8'h00, 0, 2'b00, 8'hFF, 8'h60, 2'b00, 0, 0);
        vecs[18] = mk(0, 8'h00, 1, 2'b01, 8'h00, 8'h60, 2'b01, 0, 1);
        vecs[19] = mk(0, 8'h00, 1, 2'b01, 8'h00, 8'h60, 2'b00, 0, 0);
        vecs[20] = mk(1, 8'h2F, 0, 2'b00, 8'h00, 8'h23, 2'b00, 1, 0);
        vecs[21] = mk(1, 8'hA0, 0, 2'b00, 8'h00, 8'hA0, 2'b00, 1, 0);
        vecs[22] = mk(0, 8'h00, 0, 2'b00, 8'hFF, 8'hA0, 2'b00, 0, 0);
        vecs[23] = mk(0, 8'h00, 0, 2'b00, 8'hFF, 8'hA0, 2'b00, 0, 0);
        vecs[24] = mk(0, 8'h00, 0, 2'b00, 8'h00, 8'hA0, 2'b01, AR, 0);
        vecs[25] = mk(0, 8'h00, 1, 2'b01, 8'h00, 8'hA0, 2'b00, 0, 0);
        vecs[26] = mk(1, 8'h00, 0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 0);

        preset_n = 1'b0;
        tcr_wr = 1'b0; tcr_wdata = 8'h00;
        tsr_wr = 1'b0; tsr_wdata = 2'b00; cnt = 8'h00;
        #12;
        all_zero("reset");
        @(negedge pclk);
        preset_n = 1'b1;
        @(negedge pclk);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].twr, vecs[i].twd, vecs[i].swr,
                 vecs[i].swd, vecs[i].c);
            chk($sformatf("v%0d_tcr", i), tcr, vecs[i].e_tcr);
            chk($sformatf("v%0d_tsr", i), {6'd0, tsr},
                {6'd0, vecs[i].e_tsr});
            chk($sformatf("v%0d_en", i), {7'd0, en},
                {7'd0, vecs[i].e_tcr[5]});
            chk($sformatf("v%0d_load", i), {7'd0, load},
                {7'd0, vecs[i].e_tcr[7]});
            chk($sformatf("v%0d_updown", i), {7'd0, updown},
                {7'd0, vecs[i].e_tcr[4]});
            chk($sformatf("v%0d_reconf", i), {7'd0, tcr_reconf},
                {7'd0, vecs[i].e_rc});
            chk($sformatf("v%0d_irq", i), {7'd0, irq},
                {7'd0, vecs[i].e_irq});
            @(negedge pclk);
        end

        // disabled: clk_in stays low
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 0, 2'b00, 8'h00);
            chk($sformatf("off_clk_in%0d", i), {7'd0, clk_in}, 8'h00);
            @(negedge pclk);
        end

        // /2: prescaler starts from 0, clk_in alternates 0,1,0,1...
        step(1, 8'h20, 0, 2'b00, 8'h00);
        chk("div2_reconf", {7'd0, tcr_reconf}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("div2_clk_in%0d", i), {7'd0, clk_in},
                {7'd0, logic'(i % 2)});
            @(negedge pclk);
            step(0, 8'h00, 0, 2'b00, 8'h00);
        end
        chk("div2_reconf_gone", {7'd0, tcr_reconf}, 8'h00);
        @(negedge pclk);

        // /16: 33 samples span 32 intervals -> 2 rises, 16 highs
        step(1, 8'h2F, 0, 2'b00, 8'h00);
        chk("div16_tcr", tcr, 8'h23);
        @(negedge pclk);
        tcr_wr = 1'b0;
        rises = 0;
        highs = 0;
        prev = clk_in;
        for (int i = 0; i < 32; i++) begin
            if (clk_in) highs++;
            @(negedge pclk);
            if (clk_in && !prev) rises++;
            prev = clk_in;
        end
        chk("div16_rises", 8'(rises), 8'd2);
        chk("div16_highs", 8'(highs), 8'd16);

        // set up a pending flag and pulse, then reset mid-operation
        step(1, 8'h70, 0, 2'b00, 8'h00);
        @(negedge pclk);
        step(0, 8'h00, 0, 2'b00, 8'hFF);
        chk("pre_rst_tsr", {6'd0, tsr}, 8'h02);
        chk("pre_rst_irq", {7'd0, irq}, 8'h01);
        @(negedge pclk);
        step(1, 8'hF3, 0, 2'b00, 8'hFF);
        chk("pre_rst_reconf", {7'd0, tcr_reconf}, 8'h01);
        chk("pre_rst_tcr", tcr, 8'hF3);
        #1;
        preset_n = 1'b0;
        #1;
        all_zero("midrst");
        tcr_wr = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;
        step(0, 8'h00, 0, 2'b00, 8'h00);
        all_zero("post_rst");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

endmodule
